// File: rtl/motor_pwm_timebase.sv
// rtl/motor_pwm_timebase.sv - prescaled PWM timebase with staged, wrap-aligned parameter shadow registers
module motor_pwm_timebase #(
    parameter int SIZE          = 16,
    parameter int PRESCALE_BITS = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic [PRESCALE_BITS-1:0] i_prescale,
    input  logic [SIZE-1:0]          i_period,
    input  logic [SIZE-1:0]          i_duty0,
    input  logic [SIZE-1:0]          i_duty1,
    input  logic [SIZE-1:0]          i_duty2,
    input  logic [SIZE-1:0]          i_deadband,
    input  logic                     i_load,
    input  logic                     i_commit,
    output logic [SIZE-1:0]          o_counter,
    output logic [SIZE-1:0]          o_period,
    output logic [SIZE-1:0]          o_duty0,
    output logic [SIZE-1:0]          o_duty1,
    output logic [SIZE-1:0]          o_duty2,
    output logic [SIZE-1:0]          o_deadband,
    output logic                     o_zero,
    output logic                     o_pending,
    output logic                     o_updated
);

    logic [PRESCALE_BITS-1:0] presc_q, presc_d;
    logic [SIZE-1:0] counter_q, counter_d;
    logic [SIZE-1:0] period_q, period_d, duty0_q, duty0_d, duty1_q, duty1_d;
    logic [SIZE-1:0] duty2_q, duty2_d, deadband_q, deadband_d;
    logic [SIZE-1:0] stg_period_q, stg_period_d, stg_duty0_q, stg_duty0_d;
    logic [SIZE-1:0] stg_duty1_q, stg_duty1_d, stg_duty2_q, stg_duty2_d;
    logic [SIZE-1:0] stg_deadband_q, stg_deadband_d;
    logic            zero_q, zero_d, pending_q, pending_d, updated_q, updated_d;
    logic            tick, wrap, apply;
    logic [SIZE-1:0] last_count;

    function automatic logic [SIZE-1:0] clamp(input logic [SIZE-1:0] val, input logic [SIZE-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

    always_comb begin
        // Period 0 behaves as period 1, so the last count value is 0 in both cases
        last_count = (period_q == '0) ? '0 : period_q - SIZE'(1);
        // >= keeps the prescaler from running away if i_prescale drops below the current count
        tick       = i_enable && (presc_q >= i_prescale);
        wrap       = !i_enable || (tick && (counter_q >= last_count));
        apply      = pending_q && wrap;

        presc_d        = presc_q;
        counter_d      = counter_q;
        zero_d         = 1'b0;
        period_d       = period_q;
        duty0_d        = duty0_q;
        duty1_d        = duty1_q;
        duty2_d        = duty2_q;
        deadband_d     = deadband_q;
        stg_period_d   = stg_period_q;
        stg_duty0_d    = stg_duty0_q;
        stg_duty1_d    = stg_duty1_q;
        stg_duty2_d    = stg_duty2_q;
        stg_deadband_d = stg_deadband_q;

        if (!i_enable) begin
            presc_d   = '0;
            counter_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PRESCALE_BITS'(1);
            if (wrap)
                counter_d = '0;
            else if (tick)
                counter_d = counter_q + SIZE'(1);
            zero_d = wrap;
        end

        pending_d = i_commit || (pending_q && !apply);
        updated_d = apply;

        // Transfer reads staging as it stood before this edge; a same-cycle load lands after
        if (apply) begin
            period_d   = stg_period_q;
            duty0_d    = clamp(stg_duty0_q, stg_period_q);
            duty1_d    = clamp(stg_duty1_q, stg_period_q);
            duty2_d    = clamp(stg_duty2_q, stg_period_q);
            deadband_d = clamp(stg_deadband_q, stg_period_q);
        end

        if (i_load) begin
            stg_period_d   = i_period;
            stg_duty0_d    = i_duty0;
            stg_duty1_d    = i_duty1;
            stg_duty2_d    = i_duty2;
            stg_deadband_d = i_deadband;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc_q        <= '0;
            counter_q      <= '0;
            period_q       <= '0;
            duty0_q        <= '0;
            duty1_q        <= '0;
            duty2_q        <= '0;
            deadband_q     <= '0;
            stg_period_q   <= '0;
            stg_duty0_q    <= '0;
            stg_duty1_q    <= '0;
            stg_duty2_q    <= '0;
            stg_deadband_q <= '0;
            zero_q         <= 1'b0;
            pending_q      <= 1'b0;
            updated_q      <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            counter_q      <= counter_d;
            period_q       <= period_d;
            duty0_q        <= duty0_d;
            duty1_q        <= duty1_d;
            duty2_q        <= duty2_d;
            deadband_q     <= deadband_d;
            stg_period_q   <= stg_period_d;
            stg_duty0_q    <= stg_duty0_d;
            stg_duty1_q    <= stg_duty1_d;
            stg_duty2_q    <= stg_duty2_d;
            stg_deadband_q <= stg_deadband_d;
            zero_q         <= zero_d;
            pending_q      <= pending_d;
            updated_q      <= updated_d;
        end
    end

    assign o_counter  = counter_q;
    assign o_period   = period_q;
    assign o_duty0    = duty0_q;
    assign o_duty1    = duty1_q;
    assign o_duty2    = duty2_q;
    assign o_deadband = deadband_q;
    assign o_zero     = zero_q;
    assign o_pending  = pending_q;
    assign o_updated  = updated_q;

endmodule

// File: tb/tb_motor_pwm_timebase.sv
// tb/tb_motor_pwm_timebase.sv - scoreboard bench for motor_pwm_timebase against a behavioural model
module tb_motor_pwm_timebase;
    localparam int SIZE = 16;
    localparam int PB   = 8;

    logic            clk = 1'b0;
    logic            i_reset = 1'b1, i_enable = 1'b0, i_load = 1'b0, i_commit = 1'b0;
    logic [PB-1:0]   i_prescale = '0;
    logic [SIZE-1:0] i_period = '0, i_duty0 = '0, i_duty1 = '0, i_duty2 = '0, i_deadband = '0;
    logic [SIZE-1:0] o_counter, o_period, o_duty0, o_duty1, o_duty2, o_deadband;
    logic            o_zero, o_pending, o_updated;

    motor_pwm_timebase #(.SIZE(SIZE), .PRESCALE_BITS(PB)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_prescale(i_prescale),
        .i_period(i_period), .i_duty0(i_duty0), .i_duty1(i_duty1), .i_duty2(i_duty2),
        .i_deadband(i_deadband), .i_load(i_load), .i_commit(i_commit),
        .o_counter(o_counter), .o_period(o_period), .o_duty0(o_duty0), .o_duty1(o_duty1),
        .o_duty2(o_duty2), .o_deadband(o_deadband), .o_zero(o_zero), .o_pending(o_pending),
        .o_updated(o_updated)
    );

    always #5 clk = ~clk;

    typedef logic [6*SIZE+2:0] snap_t;
    snap_t exp_q[$];
    int    n_chk = 0, n_fail = 0;

    // Stimulus data applied at the next step
    int p_pre = 0, p_per = 0, p_d0 = 0, p_d1 = 0, p_d2 = 0, p_db = 0;

    // Model: active set, staging set, counters
    int m_presc = 0, m_cnt = 0, m_per = 0, m_d0 = 0, m_d1 = 0, m_d2 = 0, m_db = 0;
    int s_per = 0, s_d0 = 0, s_d1 = 0, s_d2 = 0, s_db = 0;
    bit m_zero = 0, m_pend = 0, m_upd = 0;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic snap_t dut_snap();
        return {o_counter, o_period, o_duty0, o_duty1, o_duty2, o_deadband, o_zero, o_pending, o_updated};
    endfunction

    function automatic snap_t model_snap();
        return {SIZE'(m_cnt), SIZE'(m_per), SIZE'(m_d0), SIZE'(m_d1), SIZE'(m_d2), SIZE'(m_db),
                m_zero, m_pend, m_upd};
    endfunction

    task automatic model_reset();
        m_presc = 0; m_cnt = 0; m_per = 0; m_d0 = 0; m_d1 = 0; m_d2 = 0; m_db = 0;
        s_per = 0; s_d0 = 0; s_d1 = 0; s_d2 = 0; s_db = 0;
        m_zero = 0; m_pend = 0; m_upd = 0;
    endtask

    task automatic model_clock(input bit en, input bit ld, input bit cm);
        bit wrap, take;
        if (!en) begin
            wrap = 1; m_presc = 0; m_cnt = 0; m_zero = 0;
        end else begin
            m_presc = (m_presc + 1) % (p_pre + 1);
            wrap = 0;
            if (m_presc == 0) begin
                m_cnt = (m_cnt + 1) % ((m_per == 0) ? 1 : m_per);
                wrap = (m_cnt == 0);
            end
            m_zero = wrap;
        end
        take = m_pend && wrap;
        if (take) begin
            m_per = s_per; m_d0 = imin(s_d0, s_per); m_d1 = imin(s_d1, s_per);
            m_d2 = imin(s_d2, s_per); m_db = imin(s_db, s_per);
        end
        m_upd  = take;
        m_pend = cm || (m_pend && !take);
        if (ld) begin
            s_per = p_per; s_d0 = p_d0; s_d1 = p_d1; s_d2 = p_d2; s_db = p_db;
        end
    endtask

    task automatic step(input bit en, input bit ld, input bit cm, input bit rst);
        @(negedge clk);
        i_reset = rst; i_enable = en; i_load = ld; i_commit = cm;
        i_prescale = PB'(p_pre); i_period = SIZE'(p_per); i_duty0 = SIZE'(p_d0);
        i_duty1 = SIZE'(p_d1); i_duty2 = SIZE'(p_d2); i_deadband = SIZE'(p_db);
        if (rst) model_reset();
        else model_clock(en, ld, cm);
        exp_q.push_back(model_snap());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    task automatic set_vals(input int per, input int d0, input int d1, input int d2, input int db);
        p_per = per; p_d0 = d0; p_d1 = d1; p_d2 = d2; p_db = db;
    endtask

    // Monitor: outputs are valid every cycle; compare shortly after each active edge
    initial begin
        snap_t e, g;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = dut_snap();
                n_chk++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got cnt=%0d per=%0d d=%0d/%0d/%0d db=%0d z/p/u=%b%b%b, expected cnt=%0d per=%0d d=%0d/%0d/%0d db=%0d z/p/u=%b%b%b",
                        $time, g[98:83], g[82:67], g[66:51], g[50:35], g[34:19], g[18:3], g[2], g[1], g[0],
                        e[98:83], e[82:67], e[66:51], e[50:35], e[34:19], e[18:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        snap_t g;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // Prescale 0, period 10 committed while disabled
        set_vals(10, 3, 4, 5, 2);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        run(25);

        // Prescale 3, period 4
        step(0, 0, 0, 0);
        p_pre = 3;
        set_vals(4, 1, 2, 3, 1);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        run(40);

        // Mid-period update at counter 4
        step(0, 0, 0, 0);
        p_pre = 0;
        set_vals(10, 2, 2, 2, 1);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 40 && m_cnt != 4; i++) step(1, 0, 0, 0);
        set_vals(20, 6, 2, 2, 1);
        step(1, 1, 1, 0);
        run(20);

        // Clamping against staged period
        set_vals(200, 50, 300, 10, 250);
        step(1, 1, 1, 0);
        run(30);

        // Commit landing in a wrap-tick cycle, then a later load overrides staging
        set_vals(8, 1, 1, 1, 1);
        step(1, 1, 1, 0);
        run(210);
        for (int i = 0; i < 20 && m_cnt != m_per - 1; i++) step(1, 0, 0, 0);
        set_vals(6, 5, 4, 3, 2);
        step(1, 1, 1, 0);
        run(2);
        set_vals(5, 9, 1, 2, 3);
        step(1, 1, 0, 0);
        run(15);

        // Async reset with a commit pending
        set_vals(12, 3, 3, 3, 3);
        step(1, 1, 1, 0);
        run(1);
        @(negedge clk);
        i_reset = 1'b1;
        #1;
        g = dut_snap();
        n_chk++;
        if (g !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected 0", g);
        end
        model_reset();
        step(1, 0, 0, 1);
        run(15);

        // Randomized traffic; prescale changes only while disabled
        begin
            bit en = 1;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 39) == 0) en = !en;
                if (!en && $urandom_range(0, 1) == 1) p_pre = $urandom_range(0, 2);
                set_vals($urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 15),
                         $urandom_range(0, 15), $urandom_range(0, 15));
                step(en, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 299) == 0);
            end
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
